// File: rtl/clos_lo_rx.sv
// clos_lo_rx: SDM-Clos output-port receiver; decodes 1-of-4 four-phase sub-channels into a flit FIFO.
// Define RX_SYNC_EN to pass di0..di4 through 2-flop synchronizers (adds 2 cycles to ack set/release).
module clos_lo_rx #(
    parameter int DW  = 8,
    parameter int SCN = DW / 2,
    parameter int FD  = 4,
    parameter int AW  = $clog2(FD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SCN-1:0] di0,
    input  logic [SCN-1:0] di1,
    input  logic [SCN-1:0] di2,
    input  logic [SCN-1:0] di3,
    input  logic          di4,
    output logic          dia,
    output logic          dia4,
    output logic [DW-1:0] dout,
    output logic          deof,
    output logic          dvalid,
    input  logic          drdy,
    output logic [AW:0]   count,
    output logic          err
);
    typedef enum logic {IDLE, ACK} state_t;
    state_t state, nxt;
    logic [SCN-1:0] r0, r1, r2, r3;
    logic r4;
`ifdef RX_SYNC_EN
    logic [4*SCN:0] s1, s2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {di4, di3, di2, di1, di0};
            s2 <= s1;
        end
    end
    assign {r4, r3, r2, r1, r0} = s2;
`else
    assign {r4, r3, r2, r1, r0} = {di4, di3, di2, di1, di0};
`endif
    logic [2:0] n;
    logic complete, illegal, nul, full, push, pop, set_err, eofl;
    logic [DW-1:0] word;
    logic [DW:0] mem [FD];
    logic [AW-1:0] wptr, rptr;
    // Per sub-channel rail count: exactly one -> valid digit, more than one -> protocol error
    always_comb begin
        complete = 1'b1;
        illegal = 1'b0;
        word = '0;
        n = '0;
        for (int k = 0; k < SCN; k++) begin
            n = {2'b0, r0[k]} + {2'b0, r1[k]} + {2'b0, r2[k]} + {2'b0, r3[k]};
            complete = complete & (n == 3'd1);
            illegal = illegal | (n > 3'd1);
            word[2*k +: 2] = {r2[k] | r3[k], r1[k] | r3[k]};
        end
    end
    assign nul = ~|{r0, r1, r2, r3, r4};
    assign full = count == (AW+1)'(FD);
    assign dvalid = count != '0;
    assign pop = dvalid & drdy;
    assign dout = mem[rptr][DW-1:0];
    assign deof = mem[rptr][DW];
    assign dia = state == ACK;
    assign dia4 = dia & eofl;
    always_comb begin
        nxt = state;
        push = 1'b0;
        set_err = 1'b0;
        if (state == IDLE) begin
            set_err = illegal;
            push = complete & ~full;
            nxt = push ? ACK : IDLE;
        end else begin
            nxt = nul ? IDLE : ACK;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            err <= 1'b0;
            eofl <= 1'b0;
            count <= '0;
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < FD; i++) mem[i] <= '0;
        end else begin
            state <= nxt;
            err <= err | set_err;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) begin
                mem[wptr] <= {r4, word};
                wptr <= wptr + 1'b1;
                eofl <= r4;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_clos_lo_rx.sv
// tb_clos_lo_rx: directed bench for clos_lo_rx with a queue-based reference model checked every cycle.
module tb_clos_lo_rx;
`ifdef RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int FD = 4;
    logic clk = 0, rst_n = 0, di4 = 0, drdy = 0;
    logic [3:0] di0 = 0, di1 = 0, di2 = 0, di3 = 0;
    logic dia, dia4, deof, dvalid, err;
    logic [7:0] dout;
    logic [2:0] count;
    int n_cmp = 0, n_bad = 0;
    clos_lo_rx dut (.clk(clk), .rst_n(rst_n), .di0(di0), .di1(di1), .di2(di2), .di3(di3), .di4(di4),
        .dia(dia), .dia4(dia4), .dout(dout), .deof(deof), .dvalid(dvalid), .drdy(drdy),
        .count(count), .err(err));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Reference model: handshake flag, eof flag, sticky error and a queue of {eof, word} flits
    logic [16:0] h1 = 0, h2 = 0, raw, eff;
    bit m_ack = 0, m_eof = 0, m_err = 0, cmpl, ill, popm, fullpre;
    logic [7:0] val;
    logic [8:0] mq [$];
    int rails;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 = 0; h2 = 0; m_ack = 0; m_eof = 0; m_err = 0;
            mq.delete();
        end else begin
            raw = {di4, di3, di2, di1, di0};
            eff = (LAT == 3) ? h2 : raw;
            h2 = h1; h1 = raw;
            cmpl = 1; ill = 0; val = 0;
            for (int k = 0; k < 4; k++) begin
                rails = int'(eff[k]) + int'(eff[4+k]) + int'(eff[8+k]) + int'(eff[12+k]);
                if (rails != 1) cmpl = 0;
                if (rails > 1) ill = 1;
                val[2*k +: 2] = eff[4+k] ? 2'd1 : eff[8+k] ? 2'd2 : eff[12+k] ? 2'd3 : 2'd0;
            end
            popm = mq.size() > 0 && drdy;
            fullpre = mq.size() == FD;
            if (popm) void'(mq.pop_front());
            if (!m_ack) begin
                if (ill) m_err = 1;
                else if (cmpl && !fullpre) begin
                    mq.push_back({eff[16], val});
                    m_ack = 1;
                    m_eof = eff[16];
                end
            end else if (eff == 0) m_ack = 0;
        end
    end
    always @(negedge clk) begin
        if (rst_n) begin
            chk("dia", dia, m_ack);
            chk("dia4", dia4, m_ack && m_eof);
            chk("dvalid", dvalid, mq.size() != 0);
            chk("count", count, mq.size());
            chk("err", err, m_err);
            if (mq.size() != 0) begin
                chk("dout", dout, mq[0][7:0]);
                chk("deof", deof, mq[0][8]);
            end
        end
    end
    bit rec = 0;
    logic [8:0] got [$];
    always @(posedge clk) if (rst_n && rec && dvalid && drdy) got.push_back({deof, dout});
    task automatic drv(input logic [7:0] w, input bit e);
        for (int k = 0; k < 4; k++) begin
            di0[k] = w[2*k +: 2] == 2'd0;
            di1[k] = w[2*k +: 2] == 2'd1;
            di2[k] = w[2*k +: 2] == 2'd2;
            di3[k] = w[2*k +: 2] == 2'd3;
        end
        di4 = e;
    endtask
    task automatic clr();
        di0 = 0; di1 = 0; di2 = 0; di3 = 0; di4 = 0;
    endtask
    task automatic wait_dia(input bit v, input int maxc, output int cyc);
        bit hit = 0;
        cyc = 0;
        while (cyc < maxc && !hit) begin
            @(posedge clk); #1;
            cyc++;
            hit = dia === v;
        end
        if (!hit) cyc = -1;
    endtask
    task automatic send(input logic [7:0] w, input bit e, input bit chk_lat);
        int l;
        @(negedge clk); drv(w, e);
        wait_dia(1, 30, l);
        chk("ack_rise", (l > 0 && (!chk_lat || l == LAT)), 1);
        @(negedge clk); clr();
        wait_dia(0, 30, l);
        chk("ack_fall", (l > 0 && (!chk_lat || l == LAT)), 1);
    endtask
    task automatic pop1();
        @(negedge clk); drdy = 1;
        @(negedge clk); drdy = 0;
    endtask
    logic [8:0] exp_s [$];
    initial begin
        int l;
        logic [7:0] w;
        bit e;
        repeat (2) @(negedge clk);
        chk("rst_dia", dia, 0); chk("rst_dvalid", dvalid, 0); chk("rst_dout", dout, 0);
        chk("rst_count", count, 0); chk("rst_err", err, 0);
        rst_n = 1;
        // Single flit 0xB4 and its pinned rail encoding
        @(negedge clk); drv(8'hB4, 0);
        chk("enc_di0", di0, 4'b0001); chk("enc_di1", di1, 4'b0010);
        chk("enc_di2", di2, 4'b1000); chk("enc_di3", di3, 4'b0100);
        wait_dia(1, 20, l);
        chk("b4_lat", l, LAT); chk("b4_dia4", dia4, 0); chk("b4_dout", dout, 8'hB4);
        chk("b4_dvalid", dvalid, 1); chk("b4_count", count, 1);
        @(negedge clk); clr();
        wait_dia(0, 20, l);
        chk("b4_rel", l, LAT);
        pop1();
        chk("b4_popped", count, 0);
        // Tail flit
        @(negedge clk); drv(8'h3C, 1);
        wait_dia(1, 20, l);
        chk("t_dia4", dia4, 1); chk("t_deof", deof, 1); chk("t_dout", dout, 8'h3C);
        @(negedge clk); clr();
        wait_dia(0, 20, l);
        chk("t_dia4_drop", dia4, 0);
        pop1();
        // Backpressure: four flits fill the FIFO, fifth held until a pop
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 0, 1);
        chk("bp_count", count, 4);
        @(negedge clk); drv(8'hA5, 0);
        wait_dia(1, 8, l);
        chk("bp_held", l, 32'hFFFF_FFFF);
        pop1();
        wait_dia(1, 20, l);
        chk("bp_acked", l > 0, 1); chk("bp_count4", count, 4);
        @(negedge clk); clr();
        wait_dia(0, 20, l);
        @(negedge clk); drdy = 1;
        repeat (6) @(negedge clk);
        chk("bp_drained", count, 0);
        // Reset mid-handshake
        @(negedge clk); drv(8'h5A, 0);
        wait_dia(1, 20, l);
        #2 rst_n = 0;
        #1 chk("ar_dia", dia, 0); chk("ar_dvalid", dvalid, 0); chk("ar_count", count, 0);
        clr(); drdy = 0;
        @(negedge clk); rst_n = 1;
        // Illegal code word: sub-channel 0 with two rails
        @(negedge clk); drv(8'hB4, 0); di1[0] = 1;
        repeat (LAT + 1) @(posedge clk);
        #1 chk("il_err", err, 1); chk("il_count", count, 0); chk("il_dia", dia, 0);
        @(negedge clk); clr();
        repeat (LAT + 2) @(negedge clk);
        chk("il_sticky", err, 1);
        rst_n = 0;
        @(negedge clk); rst_n = 1;
        // Streaming with consumer always ready
        drdy = 1; rec = 1;
        for (int i = 0; i < 16; i++) begin
            w = 8'($urandom);
            e = 1'($urandom_range(0, 1));
            exp_s.push_back({e, w});
            send(w, e, 1);
        end
        repeat (4) @(negedge clk);
        chk("st_n", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("st_word", got[i], exp_s[i]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
